mac_rx_framer: RTL and testbench
================================

// Module: mac_rx_framer
// PURPOSE
//  MAC receive framing stage; sits directly downstream of the GMII reconciliation sublayer and takes the
//  same rx_clk-domain GMII byte stream (rxd/rx_dv/rx_er). It strips preamble/SFD and delimits frames with
//  sof/eof, counts length and flags errors. It also reports carrier-extend errors and keeps frame/error statistics.
// PARAMETERS
//  MIN_LEN   64    minimum legal frame length in bytes (post-SFD, FCS included)
//  MAX_LEN   1518  maximum legal frame length in bytes; longer frames are truncated
//  CNT_W     16    width of length field and statistics counters
// PORTS
//  rx_clk         in   1      GMII receive clock; all logic on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  rxd            in   8      GMII receive data
//  rx_dv          in   1      GMII receive data valid
//  rx_er          in   1      GMII receive error
//  rx_data        out  8      frame byte to MAC
//  rx_valid       out  1      rx_data valid this cycle
//  rx_sof         out  1      first byte of frame (qualified by rx_valid)
//  rx_eof         out  1      last byte of frame (qualified by rx_valid)
//  rx_frm_err     out  1      frame bad; valid only with rx_eof
//  rx_len         out  CNT_W  bytes emitted for this frame; valid only with rx_eof
//  ext_err        out  1      1-cycle pulse: carrier-extend error (rx_dv=0, rx_er=1, rxd=0x1F)
//  frame_cnt      out  CNT_W  frames delivered with rx_eof, saturating
//  err_cnt        out  CNT_W  bad frames + dropped preambles, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, hold register empty, counters 0. Async assert, sync release.
//  FSM states: IDLE, PREAMBLE, DATA, DROP.
//   IDLE: rx_dv=1 & rx_er=0 & rxd=0x55 -> PREAMBLE; rx_dv=1 & rxd=0xD5 & rx_er=0 -> DATA (shrunk preamble);
//         other rx_dv=1 byte -> DROP, err_cnt++.
//   PREAMBLE: 0x55 stay; 0xD5 -> DATA; rx_er=1, other byte, or rx_dv=0 -> DROP (IDLE if rx_dv=0), err_cnt++.
//   DATA: each sampled byte with rx_dv=1 goes to 1-byte hold register; previous held byte is emitted.
//         rx_dv=0 -> emit held byte with rx_eof=1, -> IDLE.
//   DROP: emit nothing; rx_dv=0 -> IDLE.
//  Latency: byte sampled at edge t is driven on rx_data/rx_valid from edge t+1 to edge t+2; the hold
//   register lets rx_eof coincide with the last byte. No backpressure; MAC must accept every rx_valid.
//  rx_sof on first emitted byte of frame; 1-byte frame gives rx_sof=rx_eof=1 same cycle.
//  rx_frm_err=1 at eof if: any rx_er=1 sampled in DATA, or rx_len<MIN_LEN, or truncated.
//  Length: counter clears on SFD, increments per byte emitted; rx_len = count incl. eof byte.
//  Over-length: when byte MAX_LEN is emitted, force rx_eof=1, rx_frm_err=1, rx_len=MAX_LEN, -> DROP.
//  SFD followed immediately by rx_dv=0: nothing emitted, err_cnt++, -> IDLE.
//  frame_cnt++ on every rx_eof; err_cnt++ on every rx_eof with rx_frm_err; both saturate at all-ones.
//  Carrier extend (rx_dv=0, rx_er=1, rxd=0x0F) ignored; rxd=0x1F -> ext_err pulse next cycle, any state.
//  Outputs rx_valid/sof/eof/frm_err are single-cycle; rx_data holds last value when rx_valid=0.
//  Reset mid-frame: outputs drop to 0 immediately; no eof emitted; following bytes dropped until next IDLE/SFD.
// STRUCTURE
//  Shared package: state enum (IDLE/PREAMBLE/DATA/DROP), PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5,
//   EXT_BYTE=8'h0F, EXT_ERR_BYTE=8'h1F; same constants as used by the reconciliation sublayer.
//  One sub-module: mac_rx_sat_counter (CNT_W-wide saturating increment) instanced for frame_cnt, err_cnt.
// TESTING
//  7x55,D5, 64 bytes 00..3F, rx_dv=0 -> 64 rx_valid, sof on 00, eof on 3F, rx_len=64, frm_err=0, frame_cnt=1.
//  D5 then 10 bytes -> sof/eof emitted, rx_len=10, frm_err=1 (runt), err_cnt=1.
//  55,55,D5, 100 bytes with rx_er=1 on byte 50 -> all 100 emitted, eof frm_err=1, rx_len=100.
//  55,55,D5, 1600 bytes -> eof on byte 1518 with frm_err=1, rx_len=1518, no output for remainder.
//  55,55,AA,... -> no rx_valid for frame, err_cnt++; after rx_dv=0, next good frame received normally.
//  After eof: rx_dv=0,rx_er=1,rxd=0F x3 then 1F -> no rx_valid, single ext_err pulse; rst_n low mid-frame
//   -> all outputs 0 at once, no eof, next frame clean.

Source files
------------

// File: rtl/mac_rx_framer_pkg.sv
// mac_rx_framer_pkg
//   Constants and types shared by the MAC receive framer. The byte codes are
//   the same ones the GMII reconciliation sublayer uses.
//   Contents: rx_state_t framer state enum, GMII control byte codes, and a
//   helper that decodes the carrier-extend error pattern.
package mac_rx_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] EXT_BYTE      = 8'h0F;
    localparam logic [7:0] EXT_ERR_BYTE  = 8'h1F;

    // Carrier-extend error: rx_dv low, rx_er high, rxd = 0x1F.
    function automatic logic is_ext_err(input logic dv, input logic er, input logic [7:0] d);
        return !dv && er && (d == EXT_ERR_BYTE);
    endfunction

endpackage

// File: rtl/mac_rx_sat_counter.sv
// mac_rx_sat_counter
//   CNT_W-wide counter that increments on inc and sticks at all-ones.
//   Ports:
//     rx_clk  in   1      clock, rising edge
//     rst_n   in   1      asynchronous active-low reset, clears the count
//     inc     in   1      increment request
//     cnt     out  CNT_W  current count
module mac_rx_sat_counter
    import mac_rx_framer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_rx_framer.sv
// mac_rx_framer
//   MAC receive framing stage on the GMII rx_clk domain. Strips preamble/SFD,
//   delimits frames with sof/eof, counts frame length, flags bad frames,
//   reports carrier-extend errors and keeps frame/error statistics.
//   Ports:
//     rx_clk      in   1      GMII receive clock, rising edge
//     rst_n       in   1      asynchronous active-low reset
//     rxd         in   8      GMII receive data
//     rx_dv       in   1      GMII receive data valid
//     rx_er       in   1      GMII receive error
//     rx_data     out  8      frame byte (holds last value when rx_valid=0)
//     rx_valid    out  1      rx_data valid this cycle
//     rx_sof      out  1      first byte of frame
//     rx_eof      out  1      last byte of frame
//     rx_frm_err  out  1      frame bad, valid with rx_eof
//     rx_len      out  CNT_W  bytes emitted for the frame, valid with rx_eof
//     ext_err     out  1      single-cycle carrier-extend error pulse
//     frame_cnt   out  CNT_W  frames delivered, saturating
//     err_cnt     out  CNT_W  bad frames + dropped preambles, saturating
module mac_rx_framer
    import mac_rx_framer_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic [7:0]       rxd,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_frm_err,
    output logic [CNT_W-1:0] rx_len,
    output logic             ext_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

    // Reset asserts asynchronously, releases on a clock edge.
    logic rst_meta_n;
    logic rst_sync_n;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    rx_state_t        state;
    rx_state_t        state_next;

    logic [7:0]       hold_data;
    logic             hold_valid;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_inc;
    logic             err_seen;
    logic             first_pending;

    logic             emit;
    logic             emit_eof;
    logic             trunc;
    logic             load_hold;
    logic             start_frame;
    logic             drop_err;
    logic             frm_err_next;

    assign len_inc = len + 1'b1;

    always_ff @(posedge rx_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        emit        = 1'b0;
        emit_eof    = 1'b0;
        trunc       = 1'b0;
        load_hold   = 1'b0;
        start_frame = 1'b0;
        drop_err    = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_dv) begin
                    if (!rx_er && rxd == PREAMBLE_BYTE) begin
                        state_next = PREAMBLE;
                    end else if (!rx_er && rxd == SFD_BYTE) begin
                        state_next  = DATA;
                        start_frame = 1'b1;
                    end else begin
                        state_next = DROP;
                        drop_err   = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    drop_err   = 1'b1;
                end else if (rx_er) begin
                    state_next = DROP;
                    drop_err   = 1'b1;
                end else if (rxd == SFD_BYTE) begin
                    state_next  = DATA;
                    start_frame = 1'b1;
                end else if (rxd != PREAMBLE_BYTE) begin
                    state_next = DROP;
                    drop_err   = 1'b1;
                end
            end
            DATA: begin
                if (rx_dv) begin
                    load_hold = 1'b1;
                    if (hold_valid) begin
                        emit = 1'b1;
                        // Byte MAX_LEN goes out while more data is still
                        // arriving: close the frame here and discard the rest.
                        if (len_inc == MAX_L) begin
                            emit_eof   = 1'b1;
                            trunc      = 1'b1;
                            load_hold  = 1'b0;
                            state_next = DROP;
                        end
                    end
                end else begin
                    state_next = IDLE;
                    if (hold_valid) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                    end else begin
                        // SFD followed directly by end of carrier.
                        drop_err = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign frm_err_next = err_seen || (len_inc < MIN_L) || trunc;

    always_ff @(posedge rx_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_sof        <= 1'b0;
            rx_eof        <= 1'b0;
            rx_frm_err    <= 1'b0;
            rx_len        <= '0;
            ext_err       <= 1'b0;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            len           <= '0;
            err_seen      <= 1'b0;
            first_pending <= 1'b0;
        end else begin
            rx_valid   <= emit;
            rx_sof     <= emit && first_pending;
            rx_eof     <= emit_eof;
            rx_frm_err <= emit_eof && frm_err_next;
            ext_err    <= is_ext_err(rx_dv, rx_er, rxd);

            if (emit) begin
                rx_data <= hold_data;
            end
            if (emit_eof) begin
                rx_len <= len_inc;
            end

            // The one-byte hold lets eof ride on the last byte: a byte is
            // only released once the next cycle shows whether it was last.
            hold_valid <= load_hold;
            if (load_hold) begin
                hold_data <= rxd;
            end

            if (start_frame) begin
                len           <= '0;
                err_seen      <= 1'b0;
                first_pending <= 1'b1;
            end else begin
                if (emit) begin
                    len           <= len_inc;
                    first_pending <= 1'b0;
                end
                if (load_hold && rx_er) begin
                    err_seen <= 1'b1;
                end
            end
        end
    end

    mac_rx_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .rx_clk (rx_clk),
        .rst_n  (rst_sync_n),
        .inc    (emit_eof),
        .cnt    (frame_cnt)
    );

    mac_rx_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .rx_clk (rx_clk),
        .rst_n  (rst_sync_n),
        .inc    (drop_err || (emit_eof && frm_err_next)),
        .cnt    (err_cnt)
    );

endmodule

// File: tb/tb_mac_rx_framer.sv
module tb_mac_rx_framer;

    logic        rx_clk;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_frm_err;
    logic [15:0] rx_len;
    logic        ext_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_idx, m_valid, m_sof, m_eof, m_sofeof, m_ext;
    logic [7:0]  m_sof_data, m_eof_data;
    logic [15:0] m_len;
    logic        m_err;

    int unsigned exp_frames = 0;
    int unsigned exp_errs   = 0;

    mac_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
        .rx_clk     (rx_clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_frm_err (rx_frm_err),
        .rx_len     (rx_len),
        .ext_err    (ext_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    initial rx_clk = 1'b0;
    always #4 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame payload bytes are always the low 8 bits of their index.
    always @(negedge rx_clk) begin
        if (ext_err) m_ext++;
        if (rx_valid) begin
            chk("rx_data", {24'd0, rx_data}, m_idx & 32'hFF);
            m_idx++;
            m_valid++;
            if (rx_sof) begin
                m_sof++;
                m_sof_data = rx_data;
            end
            if (rx_eof) begin
                m_eof++;
                m_eof_data = rx_data;
                m_len      = rx_len;
                m_err      = rx_frm_err;
                if (rx_sof) m_sofeof++;
            end
        end
    end

    task automatic clear_mon();
        m_idx = 0; m_valid = 0; m_sof = 0; m_eof = 0; m_sofeof = 0; m_ext = 0;
        m_sof_data = '0; m_eof_data = '0; m_len = '0; m_err = 1'b0;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        rx_dv = dv;
        rx_er = er;
        rxd   = d;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int npre, input int nbytes, input int er_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < nbytes; i++) drive(1'b1, (i == er_idx), 8'(i));
        idle(4);
    endtask

    task automatic chk_frame(input int nvalid, input logic [7:0] last, input int len,
                             input logic err);
        chk("n_valid", nvalid, m_valid);
        chk("n_sof", m_sof, 1);
        chk("sof_data", {24'd0, m_sof_data}, 32'h0);
        chk("n_eof", m_eof, 1);
        chk("eof_data", {24'd0, m_eof_data}, {24'd0, last});
        chk("rx_len", {16'd0, m_len}, len);
        chk("frm_err", {31'd0, m_err}, {31'd0, err});
        chk("frame_cnt", {16'd0, frame_cnt}, exp_frames);
        chk("err_cnt", {16'd0, err_cnt}, exp_errs);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 8'h00;
        clear_mon();
        repeat (3) @(posedge rx_clk);
        #1;
        chk("rst_valid", {31'd0, rx_valid}, 0);
        chk("rst_sof", {31'd0, rx_sof}, 0);
        chk("rst_eof", {31'd0, rx_eof}, 0);
        chk("rst_data", {24'd0, rx_data}, 0);
        chk("rst_len", {16'd0, rx_len}, 0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 0);
        chk("rst_ecnt", {16'd0, err_cnt}, 0);
        rst_n = 1'b1;
        idle(4);

        // Full preamble, 64-byte good frame
        clear_mon();
        send_frame(7, 64, -1);
        exp_frames = 1;
        chk_frame(64, 8'h3F, 64, 1'b0);

        // Shrunk preamble, 10-byte runt
        clear_mon();
        send_frame(0, 10, -1);
        exp_frames = 2; exp_errs = 1;
        chk_frame(10, 8'h09, 10, 1'b1);

        // 1-byte frame: sof and eof together
        clear_mon();
        send_frame(0, 1, -1);
        exp_frames = 3; exp_errs = 2;
        chk_frame(1, 8'h00, 1, 1'b1);
        chk("sof_eof_same", m_sofeof, 1);

        // SFD then carrier drop: nothing emitted
        clear_mon();
        send_frame(1, 0, -1);
        exp_errs = 3;
        chk("sfd_only_valid", m_valid, 0);
        chk("sfd_only_ecnt", {16'd0, err_cnt}, exp_errs);
        chk("sfd_only_fcnt", {16'd0, frame_cnt}, exp_frames);

        // rx_er inside data
        clear_mon();
        send_frame(2, 100, 50);
        exp_frames = 4; exp_errs = 4;
        chk_frame(100, 8'd99, 100, 1'b1);

        // Over-length: truncated at 1518
        clear_mon();
        send_frame(2, 1600, -1);
        exp_frames = 5; exp_errs = 5;
        chk_frame(1518, 8'hED, 1518, 1'b1);

        // Exactly MAX_LEN is legal
        clear_mon();
        send_frame(2, 1518, -1);
        exp_frames = 6;
        chk_frame(1518, 8'hED, 1518, 1'b0);

        // Bad preamble byte: whole frame dropped
        clear_mon();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
        idle(4);
        exp_errs = 6;
        chk("badpre_valid", m_valid, 0);
        chk("badpre_ecnt", {16'd0, err_cnt}, exp_errs);
        clear_mon();
        send_frame(7, 64, -1);
        exp_frames = 7;
        chk_frame(64, 8'h3F, 64, 1'b0);

        // Carrier extend and extend error
        clear_mon();
        repeat (3) drive(1'b0, 1'b1, 8'h0F);
        drive(1'b0, 1'b1, 8'h1F);
        idle(3);
        chk("ext_pulses", m_ext, 1);
        chk("ext_valid", m_valid, 0);
        chk("ext_fcnt", {16'd0, frame_cnt}, exp_frames);
        chk("ext_ecnt", {16'd0, err_cnt}, exp_errs);

        // Reset in mid-frame
        clear_mon();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
        chk("pre_rst_valid", {31'd0, rx_valid}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rx_valid}, 0);
        chk("mid_rst_data", {24'd0, rx_data}, 0);
        chk("mid_rst_fcnt", {16'd0, frame_cnt}, 0);
        chk("mid_rst_ecnt", {16'd0, err_cnt}, 0);
        clear_mon();
        for (int i = 20; i < 23; i++) drive(1'b1, 1'b0, 8'(i));
        rst_n = 1'b1;
        for (int i = 23; i < 28; i++) drive(1'b1, 1'b0, 8'(i));
        idle(4);
        exp_frames = 0; exp_errs = 1;
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_eof", m_eof, 0);
        chk("post_rst_ecnt", {16'd0, err_cnt}, exp_errs);
        clear_mon();
        send_frame(7, 64, -1);
        exp_frames = 1;
        chk_frame(64, 8'h3F, 64, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
